// File: rtl/board_writer_if.sv
// Lock/readback bundle between the game logic, the board writer and the renderer.
// The board writer (slave) owns the playfield; the master supplies landed pieces and read queries.
interface board_writer_if;
  logic        lock_valid;
  logic        lock_ready;
  logic [3:0]  x1, x2, x3, x4;
  logic [4:0]  y1, y2, y3, y4;
  logic [3:0]  rd_col;
  logic [4:0]  rd_row;
  logic        rd_cell;
  logic [15:0] score_bcd;
  logic        clear_valid;
  logic [2:0]  clear_count;
  logic        game_over;
  logic        busy;

  modport master (
    output lock_valid, x1, x2, x3, x4, y1, y2, y3, y4, rd_col, rd_row,
    input  lock_ready, rd_cell, score_bcd, clear_valid, clear_count, game_over, busy
  );

  modport slave (
    input  lock_valid, x1, x2, x3, x4, y1, y2, y3, y4, rd_col, rd_row,
    output lock_ready, rd_cell, score_bcd, clear_valid, clear_count, game_over, busy
  );
endinterface

// File: rtl/board_writer.sv
// Tetris playfield owner: writes landed pieces, removes full rows bottom-up,
// and keeps a saturating 4-digit BCD score for the renderer.
module board_writer #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic          clk,
  input  logic          reset,
  board_writer_if.slave bus
);

  localparam logic [COLS-1:0] FULL_ROW = {COLS{1'b1}};
  localparam logic [3:0]      COL_LIM  = 4'(COLS);
  localparam logic [4:0]      ROW_LIM  = 5'(ROWS);
  localparam logic [4:0]      LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [COLS-1:0] board_q [ROWS];
  logic [4:0]      r_q;
  logic [4:0]      d_q;
  logic [2:0]      count_q;
  logic [2:0]      clear_count_q;
  logic [15:0]     score_q;
  logic            game_over_q;
  logic            clear_valid_q;

  logic [3:0]      cell_x_s [4];
  logic [4:0]      cell_y_s [4];
  logic [COLS-1:0] piece_s  [ROWS];
  logic            go_hit_s;
  logic [3:0]      points_s;
  logic [16:0]     sum_s;
  logic [15:0]     score_d;
  logic            rd_cell_s;

  // Digit-wise BCD add of a small point value; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [3:0] p);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {4'b0000, c} + ((i == 0) ? {1'b0, p} : 5'd0);
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  assign cell_x_s[0] = bus.x1;
  assign cell_x_s[1] = bus.x2;
  assign cell_x_s[2] = bus.x3;
  assign cell_x_s[3] = bus.x4;
  assign cell_y_s[0] = bus.y1;
  assign cell_y_s[1] = bus.y2;
  assign cell_y_s[2] = bus.y3;
  assign cell_y_s[3] = bus.y4;

  // Piece mask and game-over detection; collisions are judged against the board before the write.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      piece_s[i] = '0;
    end
    go_hit_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      go_hit_s = go_hit_s | (cell_y_s[k] == 5'd0);
      if ((cell_x_s[k] < COL_LIM) && (cell_y_s[k] < ROW_LIM)) begin
        piece_s[cell_y_s[k]][cell_x_s[k]] = 1'b1;
        go_hit_s = go_hit_s | board_q[cell_y_s[k]][cell_x_s[k]];
      end else begin
        go_hit_s = go_hit_s;
      end
    end
  end

  // Points for the rows cleared by this lock and the saturated new score.
  always_comb begin
    case (count_q)
      3'd0:    points_s = 4'd0;
      3'd1:    points_s = 4'd1;
      3'd2:    points_s = 4'd3;
      3'd3:    points_s = 4'd5;
      3'd4:    points_s = 4'd8;
      default: points_s = 4'd0;
    endcase
    sum_s = bcd_add(score_q, points_s);
    if (sum_s[16]) begin
      score_d = 16'h9999;
    end else begin
      score_d = sum_s[15:0];
    end
  end

  // Renderer read port, live even while a lock is being processed.
  always_comb begin
    if ((bus.rd_col < COL_LIM) && (bus.rd_row < ROW_LIM)) begin
      rd_cell_s = board_q[bus.rd_row][bus.rd_col];
    end else begin
      rd_cell_s = 1'b0;
    end
  end

  // Lock / scan / shift / score sequencer; a cleared row is rescanned since the row above drops into it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < ROWS; i++) begin
        board_q[i] <= '0;
      end
      r_q           <= 5'd0;
      d_q           <= 5'd0;
      count_q       <= 3'd0;
      clear_count_q <= 3'd0;
      score_q       <= 16'h0000;
      game_over_q   <= 1'b0;
      clear_valid_q <= 1'b0;
    end else begin
      clear_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.lock_valid && !game_over_q) begin
            for (int i = 0; i < ROWS; i++) begin
              board_q[i] <= board_q[i] | piece_s[i];
            end
            game_over_q <= go_hit_s;
            r_q         <= LAST_ROW;
            count_q     <= 3'd0;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          if (board_q[r_q] == FULL_ROW) begin
            d_q     <= r_q;
            state_q <= SHIFT;
          end else if (r_q == 5'd0) begin
            state_q <= DONE;
          end else begin
            r_q <= r_q - 5'd1;
          end
        end
        SHIFT: begin
          if (d_q == 5'd0) begin
            board_q[0] <= '0;
            count_q    <= count_q + 3'd1;
            state_q    <= SCAN;
          end else begin
            board_q[d_q] <= board_q[d_q - 5'd1];
            d_q          <= d_q - 5'd1;
          end
        end
        DONE: begin
          clear_valid_q <= 1'b1;
          clear_count_q <= count_q;
          score_q       <= score_d;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.lock_ready  = (state_q == IDLE) && !game_over_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.rd_cell     = rd_cell_s;
  assign bus.score_bcd   = score_q;
  assign bus.clear_valid = clear_valid_q;
  assign bus.clear_count = clear_count_q;
  assign bus.game_over   = game_over_q;

endmodule
